// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one multi-cycle backing-memory port between the
// instruction-fetch side (I, read-only) and the data side (D, read/write).
// Each access runs IDLE -> SERVE_x -> RESP -> IDLE, so an access takes at
// least three cycles and accesses are never overlapped.
// Optional build macro MEM_ARB_RR_EN: round-robin arbitration between I and D
// using a last-grant register. Without it, D always wins over I.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no access in flight; arbitrate and launch on any request
// SERVE_I | I-side access on the memory port, waiting for mem_ack_i
// SERVE_D | D-side access on the memory port, waiting for mem_ack_i
// RESP    | one-cycle completion pulse to the side that was served
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              stall_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   any_req;
  logic   grant_d;
  logic   resp_d;

  assign any_req = i_req_i | d_req_i;

`ifdef MEM_ARB_RR_EN
  // last_d = 1 when D held the most recent grant; reset value hands the
  // first contention to D.
  logic last_d;

  // Remember which side won each arbitration round.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_d <= 1'b0;
    end else if (state == IDLE && any_req) begin
      last_d <= grant_d;
    end
  end

  assign grant_d = d_req_i & (~i_req_i | ~last_d);
`else
  assign grant_d = d_req_i;
`endif

  // State register; reset abandons any in-flight access immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; mem_ack_i only matters while an access is in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = grant_d ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_ack_i) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Memory-port registers, read-data capture and served-side tracking.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      i_rdata_o   <= '0;
      d_rdata_o   <= '0;
      resp_d      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            mem_req_o <= 1'b1;
            resp_d    <= grant_d;
            if (grant_d) begin
              mem_we_o    <= d_we_i;
              mem_addr_o  <= d_addr_i;
              mem_wdata_o <= d_wdata_i;
            end else begin
              mem_we_o   <= 1'b0;
              mem_addr_o <= i_addr_i;
            end
          end
        end
        SERVE_I: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            i_rdata_o <= mem_rdata_i;
          end
        end
        SERVE_D: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            if (!mem_we_o) begin
              d_rdata_o <= mem_rdata_i;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign i_ack_o = (state == RESP) & ~resp_d;
  assign d_ack_o = (state == RESP) &  resp_d;
  assign busy_o  = (state != IDLE);
  assign stall_o = (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o);

endmodule
